paddle_hub: RTL and testbench
=============================

Name: paddle_hub

Overview:
- Multi-channel successor to the single-channel paddle controller. Takes NUM_CH controller ports and produces one 8-bit analog value plus one fire button per channel.
- Each port can be driven by a native paddle, an analog stick or the PS/2 mouse.
- The single mouse is routed to a runtime-selected channel and keeps a separate X/Y accumulator per channel.
- Adds an accumulator recenter and an optional output slew limiter.
- Sits between hps_io and the console core's paddle_1..paddle_N / p_1..p_N inputs.

Parameters:
- NUM_CH, 4: number of controller channels (1..8).
- MOUSE_STEP_MAX, 10: per-packet clamp on mouse delta magnitude (1..127).
- STICK_THRESH, 100: positive stick deflection that switches the axis (0..127).
- SLEW_STEP, 4: maximum output change per slew tick; used only with SLEW_LIMIT_EN.
- SLEW_DIV, 256: clk cycles per slew tick (>=2); used only with SLEW_LIMIT_EN.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- inv, in, 1: invert all analog outputs (bitwise NOT).
- recenter, in, 1: single-cycle pulse; clears all mouse accumulators.
- mouse_ch, in, $clog2(NUM_CH) (min 1): channel that receives mouse events.
- stick_btn, in, NUM_CH: per-channel stick-mode select/fire.
- paddle_btn, in, NUM_CH: per-channel paddle-mode select/fire.
- joy_a, in, NUM_CH*16: per-channel {Y[15:8], X[7:0]}, signed stick axes.
- paddle, in, NUM_CH*8: per-channel native paddle position, unsigned.
- ps2_mouse, in, 25: hps_io mouse packet. [24] toggle strobe, [23:16] dy, [15:8] dx, [5] dy sign, [4] dx sign, [1:0] buttons.
- a_out, out, NUM_CH*8: per-channel analog value.
- b_out, out, NUM_CH: per-channel fire.
- src, out, NUM_CH*2: per-channel active source (debug).

Behaviour:
- **Reset (async):** src=PADDLE, xy=0 and mx=my=0 on every channel; old_stb=0; a_out=0; b_out=0; slew counter=0.
- **Mouse event:** occurs on the cycle where ps2_mouse[24] != old_stb. old_stb updates every cycle.
  - Delta: dx9={s,s,dx[7:1]}, with the same form for dy. Clamp to ±MOUSE_STEP_MAX.
  - Add to the mouse_ch channel's mx/my. Saturate the sum to -128..127; no wrap.
  - That channel's src becomes MOUSE.
  - Accumulators on other channels are untouched.
- **Recenter:** recenter=1 zeroes all mx/my on that cycle and overrides a same-cycle mouse add. src is unchanged.
- **Source priority per channel, per cycle:** paddle_btn beats stick_btn, which beats a mouse event. The winner is latched into src and held until another event.
- **Axis select (xy):**
  - MOUSE: mouse_ch channel only. buttons[1] sets xy=1, buttons[0] sets xy=0; if both, 0 wins.
  - STICK: Y non-negative and > STICK_THRESH sets xy=1; X non-negative and > STICK_THRESH sets xy=0; if both, 0 wins.
  - PADDLE: xy is not affected.
- **Target value (registered, cycle+1):**
  - PADDLE: {~p[7], p[6:0]}.
  - STICK: xy ? Y : X.
  - MOUSE: xy ? my[7:0] : mx[7:0].
- **a_out (registered, cycle+2):** target, XOR 8'hFF when inv=1. Total input-to-a_out latency is 2 clocks.
- **b_out (registered, cycle+1):**
  - PADDLE: paddle_btn.
  - STICK: stick_btn.
  - MOUSE: |buttons, only when the channel index equals mouse_ch; otherwise 0.
- **mouse_ch change:** takes effect on the next event. Accumulators persist per channel. A channel left in MOUSE with mouse_ch elsewhere keeps its last value with b_out=0.

Optional Feature:
- Macro SLEW_LIMIT_EN.
- Defined:
  - A shared counter wraps at SLEW_DIV-1 and emits one tick.
  - On a tick, each a_out moves toward (inverted) target by min(|diff|, SLEW_STEP) using unsigned 8-bit distance; no overshoot.
  - No change between ticks.
  - Reset sets a_out=0 and counter=0.
- Undefined: behaviour as above with 2-cycle latency; SLEW_STEP and SLEW_DIV are ignored.

Decomposition:
- Package paddle_pkg:
  - enum src_e {SRC_PADDLE=2'd0, SRC_STICK=2'd1, SRC_MOUSE=2'd2}.
  - Constants ACC_MIN=-128, ACC_MAX=127.
  - Function sat9 (9-bit clamp to ACC_MIN..ACC_MAX).
- Sub-module paddle_hub_ch, instantiated NUM_CH times in a generate loop. Holds src, xy, mx/my, target and the output/slew registers.
- Top level holds the strobe edge detect, delta decode/clamp, channel select one-hot and the slew tick counter.

Test Plan:
- Reset, then paddle[0]=8'h00 with no buttons -> src0=PADDLE; a_out0=8'h80 two clocks later; inv=1 -> 8'h7F.
- stick_btn1 pulse, joy_a1={8'd110, 8'd20} -> src1=STICK, xy=1, a_out1=110. Then X=105, Y=0 -> a_out1=105.
- mouse_ch=2, 20 packets with dx=+127 -> each step clamped to 10; mx2 saturates at 127, no wrap. Channels 0, 1 and 3 unchanged.
- Same cycle: paddle_btn2=1 and mouse strobe toggle -> src2=PADDLE. The mx2 add still occurs.
- recenter pulse coincident with a mouse event -> mx=my=0 on all channels; a_out2=0 (mouse mode, xy=0) two clocks later.
- SLEW_LIMIT_EN, SLEW_DIV=4, SLEW_STEP=4, target jumps 0->10 -> a_out=4, 8, 10 on consecutive ticks; constant between ticks.

Source files
------------

// File: rtl/paddle_pkg.sv
// Shared types and helpers for the multi-channel paddle hub.
package paddle_pkg;

  typedef enum logic [1:0] {
    SRC_PADDLE = 2'd0,
    SRC_STICK  = 2'd1,
    SRC_MOUSE  = 2'd2
  } src_e;

  localparam int ACC_MIN = -128;
  localparam int ACC_MAX = 127;

  // Clamp a 9-bit signed sum back into the 8-bit accumulator range.
  function automatic logic signed [7:0] sat9(input logic signed [8:0] v);
    logic signed [7:0] r;
    if (v > 9'(ACC_MAX)) begin
      r = 8'(ACC_MAX);
    end else if (v < 9'(ACC_MIN)) begin
      r = 8'(ACC_MIN);
    end else begin
      r = v[7:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/paddle_hub_ch.sv
// One controller channel: source arbitration, axis select, mouse
// accumulators, target register and analog/fire output registers.
// Optional output slew limiting is enabled by defining SLEW_LIMIT_EN.
module paddle_hub_ch
  import paddle_pkg::*;
#(
  parameter int STICK_THRESH = 100,
  parameter int SLEW_STEP    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inv,
  input  logic              recenter,
  input  logic              mouse_ev,
  input  logic              mouse_sel,
  input  logic [1:0]        mouse_btn,
  input  logic signed [8:0] dx,
  input  logic signed [8:0] dy,
  input  logic              stick_btn,
  input  logic              paddle_btn,
  input  logic [15:0]       joy,
  input  logic [7:0]        paddle,
  input  logic              tick,
  output logic [7:0]        a_out,
  output logic              b_out,
  output logic [1:0]        src
);

  src_e              src_r, src_s;
  logic              xy_r, xy_s;
  logic signed [7:0] mx_r, my_r, mx_s, my_s;
  logic signed [8:0] sum_x_s, sum_y_s;
  logic [7:0]        target_r, target_s;
  logic              b_r, b_s;
  logic [7:0]        a_r;
  logic              stick_x_hit_s, stick_y_hit_s;
  logic              own_event_s;

  assign own_event_s   = mouse_ev & mouse_sel;
  assign stick_x_hit_s = ~joy[7]  & (joy[7:0]  > 8'(STICK_THRESH));
  assign stick_y_hit_s = ~joy[15] & (joy[15:8] > 8'(STICK_THRESH));
  assign sum_x_s       = {mx_r[7], mx_r} + dx;
  assign sum_y_s       = {my_r[7], my_r} + dy;

  // Next-state for accumulators, source, axis, target and fire.
  always_comb begin
    mx_s     = mx_r;
    my_s     = my_r;
    src_s    = src_r;
    xy_s     = xy_r;
    target_s = target_r;
    b_s      = 1'b0;

    // Recenter wins over a same-cycle mouse add.
    if (recenter) begin
      mx_s = 8'sd0;
      my_s = 8'sd0;
    end else if (own_event_s) begin
      mx_s = sat9(sum_x_s);
      my_s = sat9(sum_y_s);
    end else begin
      mx_s = mx_r;
      my_s = my_r;
    end

    if (paddle_btn) begin
      src_s = SRC_PADDLE;
    end else if (stick_btn) begin
      src_s = SRC_STICK;
    end else if (own_event_s) begin
      src_s = SRC_MOUSE;
    end else begin
      src_s = src_r;
    end

    // X selection (xy=0) wins when both axis requests are present.
    case (src_s)
      SRC_MOUSE: begin
        if (mouse_sel && mouse_btn[0]) begin
          xy_s = 1'b0;
        end else if (mouse_sel && mouse_btn[1]) begin
          xy_s = 1'b1;
        end else begin
          xy_s = xy_r;
        end
      end
      SRC_STICK: begin
        if (stick_x_hit_s) begin
          xy_s = 1'b0;
        end else if (stick_y_hit_s) begin
          xy_s = 1'b1;
        end else begin
          xy_s = xy_r;
        end
      end
      default: xy_s = xy_r;
    endcase

    case (src_s)
      SRC_STICK: begin
        target_s = xy_s ? joy[15:8] : joy[7:0];
        b_s      = stick_btn;
      end
      SRC_MOUSE: begin
        target_s = xy_s ? my_s : mx_s;
        b_s      = mouse_sel & (|mouse_btn);
      end
      default: begin
        target_s = {~paddle[7], paddle[6:0]};
        b_s      = paddle_btn;
      end
    endcase
  end

  // Channel state and first pipeline stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_r    <= SRC_PADDLE;
      xy_r     <= 1'b0;
      mx_r     <= 8'sd0;
      my_r     <= 8'sd0;
      target_r <= 8'h00;
      b_r      <= 1'b0;
    end else begin
      src_r    <= src_s;
      xy_r     <= xy_s;
      mx_r     <= mx_s;
      my_r     <= my_s;
      target_r <= target_s;
      b_r      <= b_s;
    end
  end

`ifdef SLEW_LIMIT_EN
  localparam logic [7:0] STEP8 = 8'(SLEW_STEP);

  logic [7:0] want_s, dist_s, move_s, slew_s;

  // Step toward the (possibly inverted) target without overshoot.
  always_comb begin
    want_s = target_r ^ {8{inv}};
    dist_s = 8'h00;
    move_s = 8'h00;
    slew_s = a_r;
    if (want_s > a_r) begin
      dist_s = want_s - a_r;
      move_s = (dist_s > STEP8) ? STEP8 : dist_s;
      slew_s = a_r + move_s;
    end else begin
      dist_s = a_r - want_s;
      move_s = (dist_s > STEP8) ? STEP8 : dist_s;
      slew_s = a_r - move_s;
    end
  end

  // Analog output only moves on a slew tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r <= 8'h00;
    end else if (tick) begin
      a_r <= slew_s;
    end else begin
      a_r <= a_r;
    end
  end
`else
  logic unused_slew;
  assign unused_slew = ^{tick, SLEW_STEP};

  // Analog output follows the target one clock later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r <= 8'h00;
    end else begin
      a_r <= target_r ^ {8{inv}};
    end
  end
`endif

  assign a_out = a_r;
  assign b_out = b_r;
  assign src   = src_r;

endmodule

// File: rtl/paddle_hub.sv
// Multi-channel paddle hub: routes paddle, stick or PS/2 mouse input to
// NUM_CH console paddle ports. Define SLEW_LIMIT_EN for the output slew
// limiter (SLEW_STEP per tick, one tick every SLEW_DIV clocks).
module paddle_hub
  import paddle_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int MOUSE_STEP_MAX = 10,
  parameter int STICK_THRESH   = 100,
  parameter int SLEW_STEP      = 4,
  parameter int SLEW_DIV       = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inv,
  input  logic                  recenter,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] mouse_ch,
  input  logic [NUM_CH-1:0]     stick_btn,
  input  logic [NUM_CH-1:0]     paddle_btn,
  input  logic [NUM_CH*16-1:0]  joy_a,
  input  logic [NUM_CH*8-1:0]   paddle,
  input  logic [24:0]           ps2_mouse,
  output logic [NUM_CH*8-1:0]   a_out,
  output logic [NUM_CH-1:0]     b_out,
  output logic [NUM_CH*2-1:0]   src
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic signed [8:0] STEP_POS = 9'(MOUSE_STEP_MAX);
  localparam logic signed [8:0] STEP_NEG = -9'(MOUSE_STEP_MAX);

  logic              old_stb_r;
  logic              mouse_ev_s;
  logic signed [8:0] dx_raw_s, dy_raw_s, dx_s, dy_s;
  logic [NUM_CH-1:0] sel_s;
  logic              tick_s;

  function automatic logic signed [8:0] clamp_delta(input logic signed [8:0] v);
    logic signed [8:0] r;
    if (v > STEP_POS) begin
      r = STEP_POS;
    end else if (v < STEP_NEG) begin
      r = STEP_NEG;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Remember the last packet strobe level; any change is a new packet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      old_stb_r <= 1'b0;
    end else begin
      old_stb_r <= ps2_mouse[24];
    end
  end

  assign mouse_ev_s = ps2_mouse[24] ^ old_stb_r;

  // Halve the raw deltas with the packet sign and clamp per packet.
  always_comb begin
    dx_raw_s = {ps2_mouse[4], ps2_mouse[4], ps2_mouse[15:9]};
    dy_raw_s = {ps2_mouse[5], ps2_mouse[5], ps2_mouse[23:17]};
    dx_s     = clamp_delta(dx_raw_s);
    dy_s     = clamp_delta(dy_raw_s);
  end

  logic unused_bits;

`ifdef SLEW_LIMIT_EN
  localparam int DW = $clog2(SLEW_DIV);
  logic [DW-1:0] div_r;

  assign tick_s = (div_r == DW'(SLEW_DIV - 1));

  // Shared slew divider, wrapping after SLEW_DIV clocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_r <= '0;
    end else if (tick_s) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + 1'b1;
    end
  end

  assign unused_bits = ^{ps2_mouse[16], ps2_mouse[8], ps2_mouse[7:6], ps2_mouse[3:2]};
`else
  assign tick_s      = 1'b0;
  assign unused_bits = ^{ps2_mouse[16], ps2_mouse[8], ps2_mouse[7:6], ps2_mouse[3:2], SLEW_DIV};
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign sel_s[i] = (mouse_ch == CW'(i));

    paddle_hub_ch #(
      .STICK_THRESH (STICK_THRESH),
      .SLEW_STEP    (SLEW_STEP)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .inv        (inv),
      .recenter   (recenter),
      .mouse_ev   (mouse_ev_s),
      .mouse_sel  (sel_s[i]),
      .mouse_btn  (ps2_mouse[1:0]),
      .dx         (dx_s),
      .dy         (dy_s),
      .stick_btn  (stick_btn[i]),
      .paddle_btn (paddle_btn[i]),
      .joy        (joy_a[i*16 +: 16]),
      .paddle     (paddle[i*8 +: 8]),
      .tick       (tick_s),
      .a_out      (a_out[i*8 +: 8]),
      .b_out      (b_out[i]),
      .src        (src[i*2 +: 2])
    );
  end

endmodule

// File: tb/tb_paddle_hub.sv
// Self-checking bench for paddle_hub (default build, NUM_CH=4).
module tb_paddle_hub;

  localparam int N = 4;

  logic            clk;
  logic            reset;
  logic            inv;
  logic            recenter;
  logic [1:0]      mouse_ch;
  logic [N-1:0]    stick_btn;
  logic [N-1:0]    paddle_btn;
  logic [N*16-1:0] joy_a;
  logic [N*8-1:0]  paddle;
  logic [24:0]     ps2_mouse;
  logic [N*8-1:0]  a_out;
  logic [N-1:0]    b_out;
  logic [N*2-1:0]  src;

  int total;
  int bad;
  bit chk_en;

  // Behavioural model state: 0=paddle, 1=stick, 2=mouse.
  int m_src[N];
  int m_xy[N];
  int m_mx[N];
  int m_my[N];
  int m_tgt[N];
  bit m_old;
  int exp_a[N];
  int exp_b[N];
  int exp_src[N];

  paddle_hub dut (
    .clk        (clk),
    .reset      (reset),
    .inv        (inv),
    .recenter   (recenter),
    .mouse_ch   (mouse_ch),
    .stick_btn  (stick_btn),
    .paddle_btn (paddle_btn),
    .joy_a      (joy_a),
    .paddle     (paddle),
    .ps2_mouse  (ps2_mouse),
    .a_out      (a_out),
    .b_out      (b_out),
    .src        (src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int ch, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s ch%0d: got %0d expected %0d at %0t", name, ch, act, req, $time);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Half of the 8-bit magnitude, signed by the packet sign bit, limited to +-10.
  function automatic int mdelta(input logic [7:0] d, input logic s);
    int v;
    v = int'(d[7:1]);
    if (s) v = v - 128;
    return clampi(v, -10, 10);
  endfunction

  task automatic model_step();
    bit ev;
    bit sel;
    int ddx, ddy, x, y, p;
    logic signed [7:0] sx, sy;
    ev = (ps2_mouse[24] != m_old);
    m_old = ps2_mouse[24];
    ddx = mdelta(ps2_mouse[15:8], ps2_mouse[4]);
    ddy = mdelta(ps2_mouse[23:16], ps2_mouse[5]);
    for (int c = 0; c < N; c++) begin
      sel = (c == int'(mouse_ch));
      if (recenter) begin
        m_mx[c] = 0;
        m_my[c] = 0;
      end else if (ev && sel) begin
        m_mx[c] = clampi(m_mx[c] + ddx, -128, 127);
        m_my[c] = clampi(m_my[c] + ddy, -128, 127);
      end
      if (paddle_btn[c]) m_src[c] = 0;
      else if (stick_btn[c]) m_src[c] = 1;
      else if (ev && sel) m_src[c] = 2;
      sx = joy_a[c*16 +: 8];
      sy = joy_a[c*16+8 +: 8];
      x = sx;
      y = sy;
      if (m_src[c] == 2 && sel) begin
        if (ps2_mouse[0]) m_xy[c] = 0;
        else if (ps2_mouse[1]) m_xy[c] = 1;
      end else if (m_src[c] == 1) begin
        if (x > 100) m_xy[c] = 0;
        else if (y > 100) m_xy[c] = 1;
      end
      // The output loads the previous target, inverted by the current inv.
      exp_a[c] = inv ? (255 - m_tgt[c]) : m_tgt[c];
      p = int'(paddle[c*8 +: 8]);
      if (m_src[c] == 0) begin
        m_tgt[c] = (p + 128) % 256;
        exp_b[c] = paddle_btn[c];
      end else if (m_src[c] == 1) begin
        m_tgt[c] = (m_xy[c] != 0 ? y : x) & 255;
        exp_b[c] = stick_btn[c];
      end else begin
        m_tgt[c] = (m_xy[c] != 0 ? m_my[c] : m_mx[c]) & 255;
        exp_b[c] = (sel && (ps2_mouse[1] || ps2_mouse[0])) ? 1 : 0;
      end
      exp_src[c] = m_src[c];
    end
  endtask

  task automatic step();
    model_step();
    @(negedge clk);
  endtask

  // Compare every output against the model after each active edge.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      for (int c = 0; c < N; c++) begin
        check("a_out", c, int'(a_out[c*8 +: 8]), exp_a[c]);
        check("b_out", c, int'(b_out[c]), exp_b[c]);
        check("src", c, int'(src[c*2 +: 2]), exp_src[c]);
      end
    end
  end

  initial begin
    total = 0;
    bad = 0;
    chk_en = 1'b0;
    reset = 1'b1;
    inv = 1'b0;
    recenter = 1'b0;
    mouse_ch = 2'd0;
    stick_btn = '0;
    paddle_btn = '0;
    joy_a = '0;
    paddle = '0;
    ps2_mouse = '0;
    m_old = 1'b0;
    for (int c = 0; c < N; c++) begin
      m_src[c] = 0; m_xy[c] = 0; m_mx[c] = 0; m_my[c] = 0; m_tgt[c] = 0;
      exp_a[c] = 0; exp_b[c] = 0; exp_src[c] = 0;
    end
    repeat (3) @(negedge clk);
    for (int c = 0; c < N; c++) begin
      check("rst_a", c, int'(a_out[c*8 +: 8]), 0);
      check("rst_b", c, int'(b_out[c]), 0);
      check("rst_src", c, int'(src[c*2 +: 2]), 0);
    end
    reset = 1'b0;
    chk_en = 1'b1;

    // Native paddle at zero reads as mid-scale.
    step(); step();
    check("pad_a", 0, int'(a_out[7:0]), 8'h80);
    check("pad_src", 0, int'(src[1:0]), 0);
    inv = 1'b1;
    step(); step();
    check("pad_inv", 0, int'(a_out[7:0]), 8'h7F);
    inv = 1'b0;

    // Stick: Y above threshold selects Y, then X above threshold selects X.
    stick_btn[1] = 1'b1;
    joy_a[31:16] = {8'd110, 8'd20};
    step();
    stick_btn[1] = 1'b0;
    step();
    check("stick_y", 1, int'(a_out[15:8]), 110);
    check("stick_src", 1, int'(src[3:2]), 1);
    joy_a[31:16] = {8'd0, 8'd105};
    step(); step();
    check("stick_x", 1, int'(a_out[15:8]), 105);

    // Twenty max-right packets on channel 2 saturate at 127.
    mouse_ch = 2'd2;
    ps2_mouse[15:8] = 8'hFF;
    repeat (20) begin
      ps2_mouse[24] = ~ps2_mouse[24];
      step();
    end
    step();
    check("mouse_sat", 2, int'(a_out[23:16]), 127);
    check("mouse_src", 2, int'(src[5:4]), 2);
    check("other0", 0, int'(a_out[7:0]), 8'h80);
    check("other1", 1, int'(a_out[15:8]), 105);
    check("other3", 3, int'(a_out[31:24]), 8'h80);

    // Paddle button beats a same-cycle packet, but the add still lands.
    paddle_btn[2] = 1'b1;
    ps2_mouse[15:8] = 8'h00;
    ps2_mouse[4] = 1'b1;
    ps2_mouse[24] = ~ps2_mouse[24];
    step();
    check("prio_src", 2, int'(src[5:4]), 0);
    paddle_btn[2] = 1'b0;
    ps2_mouse[4] = 1'b0;
    ps2_mouse[24] = ~ps2_mouse[24];
    step(); step();
    check("prio_add", 2, int'(a_out[23:16]), 117);

    // Recenter overrides a coincident packet.
    recenter = 1'b1;
    ps2_mouse[15:8] = 8'hFF;
    ps2_mouse[24] = ~ps2_mouse[24];
    step();
    recenter = 1'b0;
    step();
    check("recenter", 2, int'(a_out[23:16]), 0);

    // Randomised traffic against the model.
    repeat (4000) begin
      paddle_btn = '0;
      stick_btn = '0;
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 9) == 0) paddle_btn[c] = 1'b1;
        if ($urandom_range(0, 9) == 0) stick_btn[c] = 1'b1;
      end
      joy_a = {$urandom, $urandom};
      paddle = $urandom;
      if ($urandom_range(0, 1) == 1) ps2_mouse[24] = ~ps2_mouse[24];
      ps2_mouse[23:0] = 24'($urandom);
      if ($urandom_range(0, 19) == 0) mouse_ch = 2'($urandom_range(0, 3));
      recenter = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 7) == 0) inv = ~inv;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
